pemstat_ctrl: RTL and testbench

Host-access sequencer for the MAC statistics block. Sits between the register-bus slave and a bank of NUM_CNT statistics counter slices, each with load, clear-on-read and carry/overflow flag. It decodes host accesses into one-hot load/clear strobes, returns the selected counter value, and gathers slice carry flags into a maskable sticky status register that drives an interrupt.

---
 rtl/pemstat_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_pemstat_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pemstat_ctrl.sv
// Host-access sequencer for the MAC statistics counter bank: decodes register-bus
// accesses into one-hot slice strobes, returns counter/status data, and collects
// slice carry flags into a maskable sticky status register that drives irq.
// Latency: request sampled at edge k, strobes live for the single ACCESS cycle
// (k..k+1), read data and host_ack registered at edge k+1, irq registered.
// Backpressure: four-phase req/ack handshake; a new request is taken only from
// IDLE, and host_ack is held until host_req is seen low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   host_req/host_wr/host_addr/host_wdata   host access request
//   host_ack/host_rdata/host_err            access completion, read data, unmapped flag
//   stat_val, stat_carry       flattened slice values and level carry flags
//   stat_ld, stat_clr, stat_carry_clr, stat_wdata   registered slice strobes and load data
//   irq                        registered interrupt, |(cstat & ~cmask)
module pemstat_ctrl #(
    parameter int NUM_CNT = 16,
    parameter int DW      = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [5:0]            host_addr,
    input  logic [DW-1:0]         host_wdata,
    output logic                  host_ack,
    output logic [DW-1:0]         host_rdata,
    output logic                  host_err,
    input  logic [NUM_CNT*DW-1:0] stat_val,
    input  logic [NUM_CNT-1:0]    stat_carry,
    output logic [NUM_CNT-1:0]    stat_ld,
    output logic [NUM_CNT-1:0]    stat_clr,
    output logic [NUM_CNT-1:0]    stat_carry_clr,
    output logic [DW-1:0]         stat_wdata,
    output logic                  irq
);

    localparam logic [5:0] A_CSTAT = 6'h3C;
    localparam logic [5:0] A_CMASK = 6'h3D;
    localparam logic [5:0] A_CTRL  = 6'h3E;
    // Counters occupy 0..NUM_CNT-1; NUM_CNT never exceeds 60 so this fits 6 bits.
    localparam logic [5:0] CNT_END = 6'(NUM_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2,
        REL    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Access latched when the request is accepted in IDLE.
    logic          wr_q;
    logic [5:0]    addr_q;
    logic [DW-1:0] wdata_q;

    // Control/status registers.
    logic [NUM_CNT-1:0] cstat;
    logic [NUM_CNT-1:0] cmask;
    logic               cor_en;

    // Next-state values for the registered outputs.
    logic               ack_nxt;
    logic [NUM_CNT-1:0] ld_nxt;
    logic [NUM_CNT-1:0] clr_nxt;
    logic [NUM_CNT-1:0] cclr_nxt;
    logic               accept;
    logic               req_is_cnt;

    // Read path, evaluated from the latched address during ACCESS.
    logic [DW-1:0] cnt_rd;
    logic [DW-1:0] rdata_nxt;
    logic          err_nxt;

    assign accept     = (state == IDLE) && host_req;
    assign req_is_cnt = (host_addr < CNT_END);

    // ------------------------------------------------------------------
    // FSM next state, ack and strobe decode.
    // Strobes are decoded from the live request in IDLE so that, once
    // registered, they are high exactly for the ACCESS cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        ld_nxt    = '0;
        clr_nxt   = '0;
        cclr_nxt  = '0;

        case (state)
            IDLE: begin
                if (host_req) begin
                    state_nxt = ACCESS;
                    for (int i = 0; i < NUM_CNT; i++) begin
                        if (host_addr == 6'(i)) begin
                            ld_nxt[i]  = host_wr;
                            clr_nxt[i] = !host_wr && cor_en;
                        end
                    end
                    if (host_wr && (host_addr == A_CSTAT)) begin
                        cclr_nxt = NUM_CNT'(host_wdata);
                    end
                    if (host_wr && (host_addr == A_CTRL) && host_wdata[1]) begin
                        clr_nxt = '1;
                    end
                end
            end
            ACCESS: begin
                state_nxt = ACK;
                ack_nxt   = 1'b1;
            end
            ACK: begin
                // A host that already let go of req gets a one-cycle ack.
                state_nxt = REL;
                ack_nxt   = host_req;
            end
            REL: begin
                if (!host_req) begin
                    state_nxt = IDLE;
                end else begin
                    ack_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read data mux.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_rd = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (addr_q == 6'(i)) begin
                cnt_rd = stat_val[i*DW +: DW];
            end
        end
    end

    always_comb begin
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        if (addr_q < CNT_END) begin
            rdata_nxt = cnt_rd;
        end else begin
            case (addr_q)
                A_CSTAT: rdata_nxt = DW'(cstat);
                A_CMASK: rdata_nxt = DW'(cmask);
                A_CTRL:  rdata_nxt = DW'(cor_en);   // gclr always reads 0
                default: err_nxt   = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch and slice strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            stat_ld        <= '0;
            stat_clr       <= '0;
            stat_carry_clr <= '0;
            stat_wdata     <= '0;
        end else begin
            stat_ld        <= ld_nxt;
            stat_clr       <= clr_nxt;
            stat_carry_clr <= cclr_nxt;
            if (accept) begin
                wr_q    <= host_wr;
                addr_q  <= host_addr;
                wdata_q <= host_wdata;
                if (host_wr && req_is_cnt) begin
                    stat_wdata <= host_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Host response and register writes, all resolved at the end of ACCESS.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_ack   <= 1'b0;
            host_rdata <= '0;
            host_err   <= 1'b0;
            cmask      <= '0;
            cor_en     <= 1'b1;
        end else begin
            host_ack <= ack_nxt;
            if (state == ACCESS) begin
                host_err <= err_nxt;
                if (!wr_q) begin
                    // Same edge as the clear-on-read strobe: the slice resolves
                    // increment+clear to 1, so the captured value loses nothing.
                    host_rdata <= rdata_nxt;
                end else begin
                    if (addr_q == A_CMASK) begin
                        cmask <= NUM_CNT'(wdata_q);
                    end
                    // A gclr write is a command only; cor_en keeps its value.
                    if ((addr_q == A_CTRL) && !wdata_q[1]) begin
                        cor_en <= wdata_q[0];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky carry status and interrupt.
    // The W1C strobe wins over a carry arriving in the same cycle; the slice
    // drops its flag on that same edge, so the bit does not re-set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstat <= '0;
            irq   <= 1'b0;
        end else begin
            cstat <= (cstat | stat_carry) & ~stat_carry_clr;
            irq   <= |(cstat & ~cmask);
        end
    end

endmodule

// File: tb/tb_pemstat_ctrl.sv
// Self-checking bench for pemstat_ctrl: table of host accesses with expected
// strobes and read data, scoreboard queue for the response, plus hand-written
// sequences for carry/irq timing, early req drop and mid-transaction reset.
module tb_pemstat_ctrl;

    localparam int NC = 16;
    localparam int DW = 31;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              host_req;
    logic              host_wr;
    logic [5:0]        host_addr;
    logic [DW-1:0]     host_wdata;
    logic              host_ack;
    logic [DW-1:0]     host_rdata;
    logic              host_err;
    logic [NC*DW-1:0]  stat_val;
    logic [NC-1:0]     stat_carry;
    logic [NC-1:0]     stat_ld;
    logic [NC-1:0]     stat_clr;
    logic [NC-1:0]     stat_carry_clr;
    logic [DW-1:0]     stat_wdata;
    logic              irq;

    always #5 clk = ~clk;

    pemstat_ctrl #(.NUM_CNT(NC), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_req       (host_req),
        .host_wr        (host_wr),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rdata     (host_rdata),
        .host_err       (host_err),
        .stat_val       (stat_val),
        .stat_carry     (stat_carry),
        .stat_ld        (stat_ld),
        .stat_clr       (stat_clr),
        .stat_carry_clr (stat_carry_clr),
        .stat_wdata     (stat_wdata),
        .irq            (irq)
    );

    typedef struct {
        string         name;
        logic          wr;
        logic [5:0]    addr;
        logic [DW-1:0] wdata;
        logic          chk_rd;
        logic [DW-1:0] rdata;
        logic          err;
        logic [NC-1:0] ld;
        logic [NC-1:0] clr;
        logic [NC-1:0] cclr;
        logic [NC-1:0] car_acc;
        logic [NC-1:0] car_post;
        int            hold;
    } vec_t;

    typedef struct {
        string         name;
        logic          chk_rd;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [DW-1:0] val(int i);
        if (i == 5) return 31'h123;
        if (i == 3) return 31'h456;
        return 31'h1000_0000 | DW'(i * 32'h111);
    endfunction

    function automatic vec_t mk(string name, logic wr, logic [5:0] addr, logic [DW-1:0] wdata,
                                logic chk_rd, logic [DW-1:0] rdata, logic err,
                                logic [NC-1:0] ld, logic [NC-1:0] clr, logic [NC-1:0] cclr,
                                int hold);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.chk_rd = chk_rd; v.rdata = rdata; v.err = err;
        v.ld = ld; v.clr = clr; v.cclr = cclr;
        v.car_acc = stat_carry; v.car_post = stat_carry;
        v.hold = hold;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   n;
        e.name = v.name; e.chk_rd = v.chk_rd; e.rdata = v.rdata; e.err = v.err;
        sb_q.push_back(e);
        host_req   = 1'b1;
        host_wr    = v.wr;
        host_addr  = v.addr;
        host_wdata = v.wdata;
        @(posedge clk); #1;                       // ACCESS cycle
        stat_carry = v.car_acc;
        chk({v.name, " ld"},   64'(stat_ld),        64'(v.ld));
        chk({v.name, " clr"},  64'(stat_clr),       64'(v.clr));
        chk({v.name, " cclr"}, 64'(stat_carry_clr), 64'(v.cclr));
        if (v.wr && (v.addr < 6'(NC)))
            chk({v.name, " wdata"}, 64'(stat_wdata), 64'(v.wdata));
        @(posedge clk); #1;                       // ack expected now
        stat_carry = v.car_post;
        n = 0;
        while (!host_ack && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk({v.name, " ack_lat"}, 64'(n), 64'd0);
        got = sb_q.pop_front();
        if (got.chk_rd)
            chk({got.name, " rdata"}, 64'(host_rdata), 64'(got.rdata));
        chk({got.name, " err"}, 64'(host_err), 64'(got.err));
        chk({v.name, " strobe_off"}, 64'({stat_ld, stat_clr, stat_carry_clr}), 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk({v.name, " ack_hold"}, 64'(host_ack), 64'd1);
        end
        host_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({v.name, " ack_rel"}, 64'(host_ack), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        rst_n      = 1'b0;
        host_req   = 1'b0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        stat_carry = '0;
        for (int i = 0; i < NC; i++) stat_val[i*DW +: DW] = val(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack",   64'(host_ack),   64'd0);
        chk("rst err",   64'(host_err),   64'd0);
        chk("rst rdata", 64'(host_rdata), 64'd0);
        chk("rst irq",   64'(irq),        64'd0);
        chk("rst strobes", 64'({stat_ld, stat_clr, stat_carry_clr}), 64'd0);
        chk("rst wdata", 64'(stat_wdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //              name            wr   addr   wdata   chk rdata  err ld       clr      cclr hold
        tbl.push_back(mk("rd_c5",       0, 6'd5,  31'h0,   1, 31'h123, 0, 16'h0,   16'h0020, 16'h0, 0));
        tbl.push_back(mk("rd_ctrl_rst", 0, 6'h3E, 31'h0,   1, 31'h1,   0, 16'h0,   16'h0,    16'h0, 1));
        tbl.push_back(mk("wr_c3",       1, 6'd3,  31'hABC, 0, 31'h0,   0, 16'h0008, 16'h0,   16'h0, 0));
        tbl.push_back(mk("wr_ctrl0",    1, 6'h3E, 31'h0,   0, 31'h0,   0, 16'h0,   16'h0,    16'h0, 0));
        tbl.push_back(mk("rd_c3_nocor", 0, 6'd3,  31'h0,   1, val(3),  0, 16'h0,   16'h0,    16'h0, 2));
        tbl.push_back(mk("rd_ctrl0",    0, 6'h3E, 31'h0,   1, 31'h0,   0, 16'h0,   16'h0,    16'h0, 0));
        tbl.push_back(mk("wr_ctrl1",    1, 6'h3E, 31'h1,   0, 31'h0,   0, 16'h0,   16'h0,    16'h0, 0));
        tbl.push_back(mk("rd_c15",      0, 6'd15, 31'h0,   1, val(15), 0, 16'h0,   16'h8000, 16'h0, 0));
        tbl.push_back(mk("rd_c0",       0, 6'd0,  31'h0,   1, val(0),  0, 16'h0,   16'h0001, 16'h0, 0));
        tbl.push_back(mk("rd_un30",     0, 6'h30, 31'h0,   1, 31'h0,   1, 16'h0,   16'h0,    16'h0, 0));
        tbl.push_back(mk("rd_un16",     0, 6'd16, 31'h0,   1, 31'h0,   1, 16'h0,   16'h0,    16'h0, 0));
        tbl.push_back(mk("wr_un30",     1, 6'h30, 31'h7FFF_FFFF, 0, 31'h0, 1, 16'h0, 16'h0,  16'h0, 0));
        tbl.push_back(mk("wr_gclr",     1, 6'h3E, 31'h2,   0, 31'h0,   0, 16'h0,   16'hFFFF, 16'h0, 0));
        tbl.push_back(mk("rd_ctrl_g",   0, 6'h3E, 31'h0,   1, 31'h1,   0, 16'h0,   16'h0,    16'h0, 0));
        tbl.push_back(mk("rd_cmask0",   0, 6'h3D, 31'h0,   1, 31'h0,   0, 16'h0,   16'h0,    16'h0, 0));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Carry on slice 7: irq two cycles after the carry.
        stat_carry = 16'h0080;
        @(posedge clk); #1;
        chk("irq_lag1", 64'(irq), 64'd0);
        @(posedge clk); #1;
        chk("irq_carry", 64'(irq), 64'd1);
        run_vec(mk("rd_cstat80", 0, 6'h3C, 31'h0,  1, 31'h80, 0, 16'h0, 16'h0, 16'h0, 0));
        run_vec(mk("wr_cmask80", 1, 6'h3D, 31'h80, 0, 31'h0,  0, 16'h0, 16'h0, 16'h0, 0));
        chk("irq_masked", 64'(irq), 64'd0);
        run_vec(mk("rd_cmask80", 0, 6'h3D, 31'h0,  1, 31'h80, 0, 16'h0, 16'h0, 16'h0, 0));
        v = mk("w1c_80", 1, 6'h3C, 31'h80, 0, 31'h0, 0, 16'h0, 16'h0, 16'h0080, 0);
        v.car_post = 16'h0;
        run_vec(v);
        run_vec(mk("rd_cstat0", 0, 6'h3C, 31'h0, 1, 31'h0, 0, 16'h0, 16'h0, 16'h0, 0));
        run_vec(mk("wr_cmask0", 1, 6'h3D, 31'h0, 0, 31'h0, 0, 16'h0, 16'h0, 16'h0, 0));
        chk("irq_clear", 64'(irq), 64'd0);

        // Carry on bits 2 and 4 in the same cycle as a W1C of bit 2.
        v = mk("w1c_race", 1, 6'h3C, 31'h4, 0, 31'h0, 0, 16'h0, 16'h0, 16'h0004, 0);
        v.car_acc  = 16'h0014;
        v.car_post = 16'h0;
        run_vec(v);
        run_vec(mk("rd_cstat10", 0, 6'h3C, 31'h0, 1, 31'h10, 0, 16'h0, 16'h0, 16'h0, 0));
        chk("irq_bit4", 64'(irq), 64'd1);

        // Reset in the middle of an acknowledged read with cor_en cleared.
        run_vec(mk("wr_ctrl0b", 1, 6'h3E, 31'h0, 0, 31'h0, 0, 16'h0, 16'h0, 16'h0, 0));
        host_req = 1'b1; host_wr = 1'b0; host_addr = 6'd5;
        @(posedge clk); #1;
        chk("rst_seq no_cor", 64'(stat_clr), 64'd0);
        @(posedge clk); #1;
        chk("rst_seq ack_pre", 64'(host_ack), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid ack", 64'(host_ack), 64'd0);
        chk("rst_mid irq", 64'(irq), 64'd0);
        chk("rst_mid strobes", 64'({stat_ld, stat_clr, stat_carry_clr}), 64'd0);
        host_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(mk("rd_ctrl_rst2", 0, 6'h3E, 31'h0, 1, 31'h1, 0, 16'h0, 16'h0, 16'h0, 0));
        run_vec(mk("rd_cstat_rst", 0, 6'h3C, 31'h0, 1, 31'h0, 0, 16'h0, 16'h0, 16'h0, 0));
        run_vec(mk("rd_c5_cor",    0, 6'd5,  31'h0, 1, 31'h123, 0, 16'h0, 16'h0020, 16'h0, 0));

        // Host drops req before ack: access completes, ack lasts one cycle.
        host_req = 1'b1; host_wr = 1'b1; host_addr = 6'h3D; host_wdata = 31'h5;
        @(posedge clk); #1;
        host_req = 1'b0;
        @(posedge clk); #1;
        chk("early ack_on", 64'(host_ack), 64'd1);
        @(posedge clk); #1;
        chk("early ack_off", 64'(host_ack), 64'd0);
        @(posedge clk); #1;
        run_vec(mk("rd_cmask5", 0, 6'h3D, 31'h0, 1, 31'h5, 0, 16'h0, 16'h0, 16'h0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
